// File: rtl/multicycle_controller.sv
// Multicycle MIPS-subset control FSM: FETCH/DECODE/EXEC/MEM/WB plus ALU decode.
// Define MC_TIMEOUT_EN to add the memory-wait timeout and the sticky ERR state.
module multicycle_controller #(
    parameter int TIMEOUT_W = 4,
    parameter int ALUFN_W   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic [5:0]         op,
    input  logic [5:0]         func,
    input  logic               Z,
    input  logic               mem_ready,
    output logic               irwrite,
    output logic               pcwrite,
    output logic               memrd,
    output logic               wr,
    output logic               werf,
    output logic [1:0]         pcsel,
    output logic [1:0]         wasel,
    output logic [1:0]         wdsel,
    output logic [1:0]         asel,
    output logic               bsel,
    output logic               sext,
    output logic [ALUFN_W-1:0] alufn,
    output logic [2:0]         state,
    output logic               illegal,
    output logic               err
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_ERR    = 3'd5
    } state_t;

    localparam logic [5:0] OP_R     = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] F_SLL  = 6'b000000;
    localparam logic [5:0] F_SRL  = 6'b000010;
    localparam logic [5:0] F_SRA  = 6'b000011;
    localparam logic [5:0] F_SLLV = 6'b000100;
    localparam logic [5:0] F_JR   = 6'b001000;
    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_ADDU = 6'b100001;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_XOR  = 6'b100110;
    localparam logic [5:0] F_NOR  = 6'b100111;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_SLTU = 6'b101011;

    localparam logic [3:0] A_ADD  = 4'd0;
    localparam logic [3:0] A_SUB  = 4'd1;
    localparam logic [3:0] A_AND  = 4'd2;
    localparam logic [3:0] A_OR   = 4'd3;
    localparam logic [3:0] A_XOR  = 4'd4;
    localparam logic [3:0] A_NOR  = 4'd5;
    localparam logic [3:0] A_SLT  = 4'd6;
    localparam logic [3:0] A_SLTU = 4'd7;
    localparam logic [3:0] A_SLL  = 4'd8;
    localparam logic [3:0] A_SRL  = 4'd9;
    localparam logic [3:0] A_SRA  = 4'd10;

    if (TIMEOUT_W < 1 || ALUFN_W < 4) begin : g_param_check
        $error("multicycle_controller: TIMEOUT_W >= 1 and ALUFN_W >= 4 required");
    end

    state_t     cur, nxt;
    logic       run, active, timeout;
    logic       r_alu, r_shamt, is_jr, is_iar, is_logi, is_lui;
    logic       is_lw, is_sw, is_beq, is_bne, is_j, is_jal;
    logic       imm_alu, legal, to_wb;
    logic [3:0] code;

    always_comb begin
        r_alu   = 1'b0;
        r_shamt = 1'b0;
        is_jr   = 1'b0;
        is_iar  = 1'b0;
        is_logi = 1'b0;
        is_lui  = 1'b0;
        is_lw   = 1'b0;
        is_sw   = 1'b0;
        is_beq  = 1'b0;
        is_bne  = 1'b0;
        is_j    = 1'b0;
        is_jal  = 1'b0;
        code    = A_ADD;
        case (op)
            OP_R: begin
                r_alu = 1'b1;
                case (func)
                    F_ADD, F_ADDU: code = A_ADD;
                    F_SUB:  code = A_SUB;
                    F_AND:  code = A_AND;
                    F_OR:   code = A_OR;
                    F_XOR:  code = A_XOR;
                    F_NOR:  code = A_NOR;
                    F_SLT:  code = A_SLT;
                    F_SLTU: code = A_SLTU;
                    F_SLLV: code = A_SLL;
                    F_SLL: begin code = A_SLL; r_shamt = 1'b1; end
                    F_SRL: begin code = A_SRL; r_shamt = 1'b1; end
                    F_SRA: begin code = A_SRA; r_shamt = 1'b1; end
                    F_JR: begin r_alu = 1'b0; is_jr = 1'b1; end
                    default: r_alu = 1'b0;
                endcase
            end
            OP_ADDI, OP_ADDIU: is_iar = 1'b1;
            OP_SLTI:  begin is_iar = 1'b1; code = A_SLT; end
            OP_SLTIU: begin is_iar = 1'b1; code = A_SLTU; end
            OP_ANDI:  begin is_logi = 1'b1; code = A_AND; end
            OP_ORI:   begin is_logi = 1'b1; code = A_OR; end
            OP_XORI:  begin is_logi = 1'b1; code = A_XOR; end
            // LUI shifts the immediate left by the constant 16 on the A port
            OP_LUI:   begin is_lui = 1'b1; code = A_SLL; end
            OP_LW:    is_lw = 1'b1;
            OP_SW:    is_sw = 1'b1;
            OP_BEQ:   begin is_beq = 1'b1; code = A_SUB; end
            OP_BNE:   begin is_bne = 1'b1; code = A_SUB; end
            OP_J:     is_j = 1'b1;
            OP_JAL:   is_jal = 1'b1;
            default: ;
        endcase
    end

    assign imm_alu = is_iar | is_logi | is_lui;
    assign to_wb   = r_alu | imm_alu;
    assign legal   = to_wb | is_jr | is_lw | is_sw | is_beq | is_bne
                   | is_j | is_jal;

    assign alufn = ALUFN_W'(code);
    assign asel  = is_lui ? 2'b10 : (r_shamt ? 2'b01 : 2'b00);
    assign bsel  = imm_alu | is_lw | is_sw;
    assign sext  = is_iar | is_lw | is_sw | is_beq | is_bne;
    assign wasel = r_alu ? 2'b00
                 : (imm_alu | is_lw) ? 2'b01
                 : is_jal ? 2'b10 : 2'b00;
    assign wdsel = is_lw ? 2'b10 : (to_wb ? 2'b01 : 2'b00);

    // run holds the FSM idle until the first edge after reset release
    assign active = run & enable;

`ifdef MC_TIMEOUT_EN
    localparam logic [TIMEOUT_W-1:0] LAST =
        {TIMEOUT_W{1'b1}} ^ TIMEOUT_W'(1);

    logic [TIMEOUT_W-1:0] cnt;
    logic                 waiting;

    assign waiting = active & ~mem_ready
                   & ((cur == S_FETCH) | (cur == S_MEM));
    assign timeout = waiting & (cnt == LAST);
    assign err     = (cur == S_ERR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (active) begin
            if (waiting && nxt == cur) cnt <= cnt + 1'b1;
            else                       cnt <= '0;
        end
    end
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur <= S_FETCH;
            run <= 1'b0;
        end else begin
            run <= 1'b1;
            cur <= nxt;
        end
    end

    always_comb begin
        nxt     = cur;
        irwrite = 1'b0;
        pcwrite = 1'b0;
        memrd   = 1'b0;
        wr      = 1'b0;
        werf    = 1'b0;
        illegal = 1'b0;
        pcsel   = 2'b00;
        unique case (cur)
            S_FETCH: begin
                memrd = 1'b1;
                if (mem_ready) begin
                    irwrite = 1'b1;
                    pcwrite = 1'b1;
                    nxt     = S_DECODE;
                end else if (timeout) begin
                    nxt = S_ERR;
                end
            end
            S_DECODE: begin
                if (legal) begin
                    nxt = S_EXEC;
                end else begin
                    illegal = 1'b1;
                    nxt     = S_FETCH;
                end
            end
            S_EXEC: begin
                nxt = S_FETCH;
                if (to_wb) begin
                    nxt = S_WB;
                end else if (is_lw | is_sw) begin
                    nxt = S_MEM;
                end else if (is_beq | is_bne) begin
                    pcsel   = 2'b01;
                    pcwrite = is_beq ? Z : ~Z;
                end else if (is_j | is_jal) begin
                    pcsel   = 2'b10;
                    pcwrite = 1'b1;
                    werf    = is_jal;
                end else if (is_jr) begin
                    pcsel   = 2'b11;
                    pcwrite = 1'b1;
                end
            end
            S_MEM: begin
                memrd = is_lw;
                wr    = is_sw;
                if (mem_ready)    nxt = is_lw ? S_WB : S_FETCH;
                else if (timeout) nxt = S_ERR;
            end
            S_WB: begin
                werf = 1'b1;
                nxt  = S_FETCH;
            end
            S_ERR:   nxt = S_ERR;
            default: nxt = S_FETCH;
        endcase
        if (!active) begin
            nxt     = cur;
            irwrite = 1'b0;
            pcwrite = 1'b0;
            memrd   = 1'b0;
            wr      = 1'b0;
            werf    = 1'b0;
            illegal = 1'b0;
        end
    end

    assign state = cur;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: vector table, directed corner cases and a
// randomized run against an instruction-level phase-list reference model.
module tb_multicycle_controller;

    localparam int TW = 4;

    typedef enum {
        K_RALU, K_RSH, K_JR, K_IALU, K_LOGI, K_LUI,
        K_LW, K_SW, K_BEQ, K_BNE, K_J, K_JAL, K_ILL
    } kind_e;

    typedef struct {
        logic [5:0] op;
        logic [5:0] func;
        kind_e      k;
    } ins_t;

    typedef struct {
        string       name;
        logic [5:0]  op;
        logic [5:0]  func;
        logic        z;
        int          n;
        logic [19:0] seq;
        logic        pcw;
        logic        wf;
        logic [1:0]  was;
        logic [1:0]  wds;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n, enable, Z, mem_ready;
    logic [5:0] op, func;
    logic       irwrite, pcwrite, memrd, wr, werf, bsel, sext, illegal, err;
    logic [1:0] pcsel, wasel, wdsel, asel;
    logic [3:0] alufn;
    logic [2:0] state;

    int errors = 0;
    int checks = 0;

    ins_t itab[$];
    int   ph_q[$];
    vec_t vecs[15];

    multicycle_controller #(.TIMEOUT_W(TW), .ALUFN_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .op(op), .func(func),
        .Z(Z), .mem_ready(mem_ready), .irwrite(irwrite), .pcwrite(pcwrite),
        .memrd(memrd), .wr(wr), .werf(werf), .pcsel(pcsel), .wasel(wasel),
        .wdsel(wdsel), .asel(asel), .bsel(bsel), .sext(sext), .alufn(alufn),
        .state(state), .illegal(illegal), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drv(input logic en, input logic mr, input logic z);
        enable = en;
        mem_ready = mr;
        Z = z;
        #2;
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic reset_dut;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        enable = 1'b1;
        mem_ready = 1'b0;
        tick();
    endtask

    task automatic add(input logic [5:0] o, input logic [5:0] f, input kind_e k);
        ins_t t;
        t.op = o;
        t.func = f;
        t.k = k;
        itab.push_back(t);
    endtask

    function automatic ins_t pick();
        ins_t t = itab[$urandom_range(itab.size() - 1)];
        if (t.op != 6'd0) t.func = 6'($urandom);
        return t;
    endfunction

    task automatic load_plan(input kind_e k);
        ph_q = {0, 1};
        if (k != K_ILL) ph_q.push_back(2);
        if (k inside {K_LW, K_SW}) ph_q.push_back(3);
        if (k inside {K_RALU, K_RSH, K_IALU, K_LOGI, K_LUI, K_LW})
            ph_q.push_back(4);
    endtask

    task automatic reset_abort(input string nm, input logic [5:0] o,
                               input logic [5:0] f, input int exp_st);
        op = o;
        func = f;
        for (int i = 0; i < 3; i++) begin
            drv(1'b1, 1'b1, 1'b0);
            tick();
        end
        drv(1'b1, 1'b0, 1'b0);
        chk({nm, "_pre_state"}, state, exp_st);
        #1 rst_n = 1'b0;
        #1;
        chk({nm, "_rst_state"}, state, 0);
        chk({nm, "_rst_strobes"}, {irwrite, pcwrite, memrd, wr, werf}, 0);
        @(posedge clk);
        #1;
        chk({nm, "_rst_hold"}, {irwrite, pcwrite, memrd, wr, werf, err}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        drv(1'b1, 1'b0, 1'b0);
        tick();
        drv(1'b1, 1'b0, 1'b0);
        chk({nm, "_refetch"}, {state, memrd}, 1);
    endtask

    initial begin
        ins_t        cur;
        int          ph, wait_run, cnt0;
        logic        en, mr, z, pcw;
        logic [5:0]  es;
        logic [1:0]  eps, eas;

        vecs[0]  = '{"add",  6'h00, 6'h20, 1'b0, 4, 20'h01240, 1'b0, 1'b1, 2'd0, 2'd1};
        vecs[1]  = '{"sll",  6'h00, 6'h00, 1'b0, 4, 20'h01240, 1'b0, 1'b1, 2'd0, 2'd1};
        vecs[2]  = '{"sra",  6'h00, 6'h03, 1'b1, 4, 20'h01240, 1'b0, 1'b1, 2'd0, 2'd1};
        vecs[3]  = '{"addi", 6'h08, 6'h15, 1'b0, 4, 20'h01240, 1'b0, 1'b1, 2'd1, 2'd1};
        vecs[4]  = '{"lui",  6'h0F, 6'h00, 1'b0, 4, 20'h01240, 1'b0, 1'b1, 2'd1, 2'd1};
        vecs[5]  = '{"ori",  6'h0D, 6'h2A, 1'b0, 4, 20'h01240, 1'b0, 1'b1, 2'd1, 2'd1};
        vecs[6]  = '{"lw",   6'h23, 6'h00, 1'b0, 5, 20'h01234, 1'b0, 1'b1, 2'd1, 2'd2};
        vecs[7]  = '{"sw",   6'h2B, 6'h00, 1'b0, 4, 20'h01230, 1'b0, 1'b0, 2'd0, 2'd0};
        vecs[8]  = '{"beq1", 6'h04, 6'h00, 1'b1, 3, 20'h01200, 1'b1, 1'b0, 2'd0, 2'd0};
        vecs[9]  = '{"beq0", 6'h04, 6'h00, 1'b0, 3, 20'h01200, 1'b0, 1'b0, 2'd0, 2'd0};
        vecs[10] = '{"bne1", 6'h05, 6'h00, 1'b1, 3, 20'h01200, 1'b0, 1'b0, 2'd0, 2'd0};
        vecs[11] = '{"bne0", 6'h05, 6'h00, 1'b0, 3, 20'h01200, 1'b1, 1'b0, 2'd0, 2'd0};
        vecs[12] = '{"j",    6'h02, 6'h00, 1'b0, 3, 20'h01200, 1'b1, 1'b0, 2'd0, 2'd0};
        vecs[13] = '{"jal",  6'h03, 6'h00, 1'b0, 3, 20'h01200, 1'b1, 1'b1, 2'd2, 2'd0};
        vecs[14] = '{"jr",   6'h00, 6'h08, 1'b0, 3, 20'h01200, 1'b1, 1'b0, 2'd0, 2'd0};

        add(6'h00, 6'h20, K_RALU); add(6'h00, 6'h21, K_RALU);
        add(6'h00, 6'h22, K_RALU); add(6'h00, 6'h24, K_RALU);
        add(6'h00, 6'h25, K_RALU); add(6'h00, 6'h26, K_RALU);
        add(6'h00, 6'h27, K_RALU); add(6'h00, 6'h2A, K_RALU);
        add(6'h00, 6'h2B, K_RALU); add(6'h00, 6'h04, K_RALU);
        add(6'h00, 6'h00, K_RSH);  add(6'h00, 6'h02, K_RSH);
        add(6'h00, 6'h03, K_RSH);  add(6'h00, 6'h08, K_JR);
        add(6'h00, 6'h3F, K_ILL);  add(6'h00, 6'h01, K_ILL);
        add(6'h08, 6'h00, K_IALU); add(6'h09, 6'h00, K_IALU);
        add(6'h0A, 6'h00, K_IALU); add(6'h0B, 6'h00, K_IALU);
        add(6'h0C, 6'h00, K_LOGI); add(6'h0D, 6'h00, K_LOGI);
        add(6'h0E, 6'h00, K_LOGI); add(6'h0F, 6'h00, K_LUI);
        add(6'h23, 6'h00, K_LW);   add(6'h2B, 6'h00, K_SW);
        add(6'h04, 6'h00, K_BEQ);  add(6'h05, 6'h00, K_BNE);
        add(6'h02, 6'h00, K_J);    add(6'h03, 6'h00, K_JAL);
        add(6'h3F, 6'h00, K_ILL);  add(6'h01, 6'h00, K_ILL);
        add(6'h20, 6'h00, K_ILL);  add(6'h06, 6'h00, K_ILL);

        // reset state
        rst_n = 1'b0;
        enable = 1'b1;
        mem_ready = 1'b1;
        Z = 1'b0;
        op = 6'h00;
        func = 6'h20;
        @(negedge clk);
        #2;
        chk("reset_state", state, 0);
        chk("reset_strobes", {irwrite, pcwrite, memrd, wr, werf, illegal}, 0);
        chk("reset_err", err, 0);
        rst_n = 1'b1;
        drv(1'b1, 1'b0, 1'b0);
        chk("prerun_memrd", memrd, 0);
        tick();
        drv(1'b1, 1'b0, 1'b0);
        chk("first_fetch", {state, memrd}, 1);

        // vector table, memory always ready
        foreach (vecs[v]) begin
            op = vecs[v].op;
            func = vecs[v].func;
            for (int i = 0; i < vecs[v].n; i++) begin
                drv(1'b1, 1'b1, vecs[v].z);
                chk({vecs[v].name, "_state"}, state, vecs[v].seq[19 - 4 * i -: 4]);
                if (i == 2) chk({vecs[v].name, "_pcwrite"}, pcwrite, vecs[v].pcw);
                if (i == vecs[v].n - 1) begin
                    chk({vecs[v].name, "_werf"}, werf, vecs[v].wf);
                    if (vecs[v].wf) begin
                        chk({vecs[v].name, "_wasel"}, wasel, vecs[v].was);
                        chk({vecs[v].name, "_wdsel"}, wdsel, vecs[v].wds);
                    end
                end
                tick();
            end
            drv(1'b1, 1'b1, 1'b0);
            chk({vecs[v].name, "_back_fetch"}, state, 0);
        end

        // LW with two extra MEM wait cycles
        op = 6'h23;
        func = 6'h00;
        for (int i = 0; i < 3; i++) begin
            drv(1'b1, 1'b1, 1'b0);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            drv(1'b1, i == 2, 1'b0);
            chk("lw_mem_state", {state, memrd}, 7);
            tick();
        end
        drv(1'b1, 1'b0, 1'b0);
        chk("lw_wb", {state, werf, wdsel}, {3'd4, 1'b1, 2'b10});
        tick();
        drv(1'b1, 1'b1, 1'b0);
        chk("lw_done", state, 0);

        // unknown opcode
        op = 6'h3F;
        drv(1'b1, 1'b1, 1'b0);
        tick();
        drv(1'b1, 1'b1, 1'b0);
        chk("ill_decode", {state, illegal}, 3);
        chk("ill_no_write", {werf, wr, pcwrite}, 0);
        tick();
        drv(1'b1, 1'b1, 1'b0);
        chk("ill_next", {state, illegal}, 0);

        // SW stalled by enable=0 for three MEM cycles
        op = 6'h2B;
        for (int i = 0; i < 3; i++) begin
            drv(1'b1, 1'b1, 1'b0);
            tick();
        end
        drv(1'b1, 1'b0, 1'b0);
        chk("sw_mem", {state, wr}, 7);
        tick();
        for (int i = 0; i < 3; i++) begin
            drv(1'b0, 1'b1, 1'b0);
            chk("sw_frozen", {state, wr}, 6);
            tick();
        end
        drv(1'b1, 1'b0, 1'b0);
        chk("sw_resume", {state, wr}, 7);
        tick();
        drv(1'b1, 1'b1, 1'b0);
        chk("sw_ready", {state, wr}, 7);
        tick();
        drv(1'b1, 1'b1, 1'b0);
        chk("sw_done", state, 0);

        reset_abort("rst_mem", 6'h23, 6'h00, 3);
        reset_abort("rst_wb", 6'h00, 6'h20, 4);

        reset_dut();
        cnt0 = 0;
`ifdef MC_TIMEOUT_EN
        for (int i = 0; i < (1 << TW) - 1; i++) begin
            drv(1'b1, 1'b0, 1'b0);
            if (state == 3'd0 && memrd) cnt0++;
            tick();
        end
        chk("to_wait_cycles", cnt0, (1 << TW) - 1);
        drv(1'b1, 1'b0, 1'b0);
        chk("to_err_state", {state, err}, {3'd5, 1'b1});
        chk("to_err_strobes", {irwrite, pcwrite, memrd, wr, werf}, 0);
        for (int i = 0; i < 4; i++) begin
            drv(1'b1, 1'b1, 1'b0);
            tick();
        end
        drv(1'b1, 1'b1, 1'b0);
        chk("to_err_sticky", {state, err}, {3'd5, 1'b1});
        rst_n = 1'b0;
        #1;
        chk("to_err_cleared", {state, err}, 0);
`else
        for (int i = 0; i < 40; i++) begin
            drv(1'b1, 1'b0, 1'b0);
            if (state == 3'd0 && memrd && !err) cnt0++;
            tick();
        end
        chk("nto_wait_cycles", cnt0, 40);
        drv(1'b1, 1'b1, 1'b0);
        tick();
        drv(1'b1, 1'b1, 1'b0);
        chk("nto_decode", {state, err}, 2);
`endif
        reset_dut();

        // randomized run against the phase-list model
        cur = pick();
        op = cur.op;
        func = cur.func;
        load_plan(cur.k);
        wait_run = 0;
        for (int c = 0; c < 3000; c++) begin
            ph = ph_q[0];
            en = ($urandom_range(7) != 0);
            z = 1'($urandom_range(1));
            mr = 1'($urandom_range(1));
            if (wait_run >= 8) mr = 1'b1;
            drv(en, mr, z);

            es = '0;
            eps = 2'b00;
            pcw = ((cur.k == K_BEQ) && z) || ((cur.k == K_BNE) && !z)
                || (cur.k inside {K_J, K_JAL, K_JR});
            if (en) begin
                case (ph)
                    0: es = {mr, mr, 1'b1, 3'b000};
                    1: es[0] = (cur.k == K_ILL);
                    2: begin es[4] = pcw; es[1] = (cur.k == K_JAL); end
                    3: begin es[3] = (cur.k == K_LW); es[2] = (cur.k == K_SW); end
                    default: es[1] = 1'b1;
                endcase
            end
            if (ph == 2) begin
                if (cur.k inside {K_BEQ, K_BNE}) eps = 2'b01;
                else if (cur.k inside {K_J, K_JAL}) eps = 2'b10;
                else if (cur.k == K_JR) eps = 2'b11;
            end
            eas = (cur.k == K_LUI) ? 2'b10 : ((cur.k == K_RSH) ? 2'b01 : 2'b00);

            chk("rnd_state", state, ph);
            chk("rnd_strobes", {irwrite, pcwrite, memrd, wr, werf, illegal}, es);
            chk("rnd_err", err, 0);
            chk("rnd_asel", asel, eas);
            if (es[4]) chk("rnd_pcsel", pcsel, eps);
            if (es[1]) begin
                if (cur.k == K_JAL) chk("rnd_wsel_jal", {wasel, wdsel}, 4'b1000);
                else if (cur.k == K_LW) chk("rnd_wsel_lw", {wasel, wdsel}, 4'b0110);
                else if (cur.k inside {K_RALU, K_RSH})
                    chk("rnd_wsel_r", {wasel, wdsel}, 4'b0001);
                else chk("rnd_wsel_i", {wasel, wdsel}, 4'b0101);
            end
            if (cur.k inside {K_RALU, K_RSH}) chk("rnd_bsel_r", bsel, 0);
            if (cur.k inside {K_IALU, K_LOGI, K_LUI, K_LW, K_SW})
                chk("rnd_bsel_i", bsel, 1);
            if (cur.k inside {K_IALU, K_LW, K_SW}) chk("rnd_sext1", sext, 1);
            if (cur.k == K_LOGI) chk("rnd_sext0", sext, 0);

            tick();

            if (ph == 0 || ph == 3) wait_run = (en && mr) ? 0 : wait_run + 1;
            else wait_run = 0;
            if (en && ((ph != 0 && ph != 3) || mr)) begin
                void'(ph_q.pop_front());
                if (ph_q.size() == 0) begin
                    cur = pick();
                    op = cur.op;
                    func = cur.func;
                    load_plan(cur.k);
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter TIMEOUT_W, default 4, sets the width of the memory-wait counter; the timeout limit is 2^TIMEOUT_W-1 cycles.
REQ-002 Parameter ALUFN_W, default 4, sets the width of alufn.
REQ-003 clk  input  1  single clock; all state updates occur on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  processor run enable.
REQ-006 op, func  input  6 each  opcode and R-type function field from the instruction register.
REQ-007 Z  input  1  ALU zero flag.
REQ-008 mem_ready  input  1  memory completion handshake.
REQ-009 irwrite, pcwrite  output  1 each  instruction-register load and PC load strobes.
REQ-010 memrd, wr, werf  output  1 each  memory read, memory write and register-file write strobes.
REQ-011 pcsel, wasel, wdsel, asel  output  2 each; bsel, sext  output  1 each  datapath selects, with the same encodings as the single-cycle controller.
REQ-012 alufn  output  ALUFN_W  ALU function code from the ALU decoder.
REQ-013 state  output  3  current FSM state.
REQ-014 illegal  output  1  one-cycle pulse on an unknown instruction.
REQ-015 err  output  1  sticky timeout error.

Function
REQ-016 States, with their state encodings:
- FETCH=0
- DECODE=1
- EXEC=2
- MEM=3
- WB=4
- ERR=5
REQ-017 FETCH: memrd=1 and the FSM waits for mem_ready; on mem_ready it asserts irwrite=1, pcwrite=1 and pcsel=00 for that cycle, then goes to DECODE.
REQ-018 DECODE: a supported op/func goes to EXEC; any other value pulses illegal=1 and goes to FETCH with no write strobe.
REQ-019 Supported opcodes and functs:
- Opcodes: LW 100011, SW 101011, ADDI, ADDIU, SLTI, SLTIU, ANDI, ORI, XORI, LUI, BEQ 000100, BNE 000101, J 000010, JAL 000011.
- R-type functs: ADD, ADDU, SUB, AND, OR, XOR, NOR, SLT, SLTU, SLLV, SLL, SRL, SRA, JR.
REQ-020 EXEC, ALU instructions (R-type and immediate): go to WB.
REQ-021 EXEC, LW and SW: go to MEM.
REQ-022 EXEC, BEQ/BNE: pcwrite=1 with pcsel=01 only if the branch is taken (BEQ with Z=1, BNE with Z=0); then go to FETCH.
REQ-023 EXEC, J: pcwrite=1, pcsel=10, then FETCH.
REQ-024 EXEC, JAL: pcwrite=1, pcsel=10, werf=1, wasel=10, wdsel=00, then FETCH.
REQ-025 EXEC, JR: pcwrite=1, pcsel=11, then FETCH.
REQ-026 MEM, LW: memrd=1 until mem_ready, then go to WB.
REQ-027 MEM, SW: wr=1 until mem_ready, then go to FETCH.
REQ-028 WB: werf=1 for exactly one cycle.
- LW: wdsel=10.
- Other instructions: wdsel=01.
- R-type: wasel=00; all others: wasel=01.
- After WB, go to FETCH.
REQ-029 Select outputs (wasel, wdsel, asel, bsel, sext) are decoded from op/func in every state.
- The values match the single-cycle controller table: LUI asel=10; SLL/SRL/SRA asel=01; ANDI/ORI/XORI sext=0.
- Don't-care fields are driven 0.
REQ-030 alufn is driven combinationally by the existing ALU decoder from op/func in all states.
REQ-031 Strobes are Moore outputs of state and op/func, except the branch pcwrite, which also depends on Z.
REQ-032 Minimum cycle counts, excluding memory waits:
- Branch, J, JAL, JR: 3 cycles.
- ALU and SW: 4 cycles.
- LW: 5 cycles.
REQ-033 enable=0 freezes state and the timeout counter, and forces irwrite, pcwrite, memrd, wr and werf to 0.
REQ-034 enable returning to 1 resumes from the frozen state.
REQ-035 mem_ready outside FETCH/MEM is ignored.
REQ-036 mem_ready arriving in the same cycle as the enable=0 transition is ignored.

Reset
REQ-037 rst_n=0 immediately forces:
- state=FETCH;
- all strobes, illegal and err to 0;
- the timeout counter to 0.
REQ-038 Reset asserted mid-MEM or mid-WB aborts the instruction with no write strobe after assertion.
REQ-039 The first FETCH begins on the first rising clk edge after rst_n deasserts.

Configuration
REQ-040 With MC_TIMEOUT_EN defined, the memory-wait timeout logic is included:
- A counter increments on each waiting cycle in FETCH or MEM and clears on mem_ready or on a state change.
- When the counter reaches 2^TIMEOUT_W-1 without mem_ready, the FSM goes to ERR.
- In ERR, err=1, all strobes are 0, and the FSM stays until reset.
REQ-041 Without MC_TIMEOUT_EN, the FSM waits indefinitely for mem_ready, err is tied 0, and ERR is unreachable.

Verification
REQ-042 ADD (op=000000, func=100000), mem_ready=1 always -> states 0,1,2,4,0; werf=1 only in WB, wasel=00, wdsel=01.
REQ-043 LW with mem_ready delayed 2 cycles in MEM -> MEM lasts 3 cycles with memrd=1, then WB with werf=1, wdsel=10.
REQ-044 BEQ with Z=1, then BNE with Z=1 -> BEQ gives pcwrite=1, pcsel=01 in EXEC; BNE gives pcwrite=0; both return to FETCH.
REQ-045 op=111111 -> illegal pulses 1 cycle in DECODE; no werf, wr or pcwrite; the next state is FETCH.
REQ-046 SW with enable dropped for 3 cycles during MEM -> wr=0 while disabled, state held at 3, store completes after enable=1.
REQ-047 MC_TIMEOUT_EN, TIMEOUT_W=4, mem_ready stuck 0 in FETCH -> ERR after 15 wait cycles, err=1 until rst_n=0.
